// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, default constants and divider helper
//
// Contents:
//   uart_state_t    receiver/transmitter FSM states (IDLE, START, DATA, STOP)
//   baud_dvsr()     clk cycles per 16x oversample tick for a clock/baud pair
//   DEFAULT_DVSR    divider for 100 MHz, 115200 baud
//   DEFAULT_SB_TICK oversample ticks for one stop bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Integer division truncates, so the tick runs slightly fast; at
    // 100 MHz / 115200 the error is well inside UART tolerance.
    function automatic int baud_dvsr(input int clk_hz, input int baud);
        return clk_hz / (16 * baud);
    endfunction

    localparam int DEFAULT_DVSR    = baud_dvsr(100_000_000, 115_200);
    localparam int DEFAULT_SB_TICK = 16;

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - free-running mod-DVSR divider producing the oversample tick
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset (counter to 0)
//   s_tick  one-clk pulse every DVSR clocks, while count == DVSR-1
module baud_gen #(
    parameter int DVSR      = 54,
    parameter int DVSR_BITS = 6
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick
);

    logic [DVSR_BITS-1:0] count;

    // Never resynchronised to the rx start edge; the receiver tolerates up
    // to one tick of phase error.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == DVSR_BITS'(DVSR - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign s_tick = (count == DVSR_BITS'(DVSR - 1));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver writing bytes into the rx fifo
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx         asynchronous serial line, idle high
//   fifo_full  full flag from the downstream fifo
//   wr         one-clk write strobe to the fifo
//   w_data     received byte, valid while wr=1, held until the next wr
//   frame_err  one-clk pulse: stop bit sampled low
//   overrun    one-clk pulse: good byte dropped because the fifo was full
import uart_pkg::*;

module uart_rx #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = DEFAULT_SB_TICK,
    parameter int DVSR      = DEFAULT_DVSR,
    parameter int DVSR_BITS = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            fifo_full,
    output logic            wr,
    output logic [DBIT-1:0] w_data,
    output logic            frame_err,
    output logic            overrun
);

    localparam int S_BITS = (SB_TICK > 16) ? 5 : 4;
    localparam int N_BITS = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic              s_tick;
    logic              rx_meta;
    logic              rx_s;
    uart_state_t       state;
    logic [S_BITS-1:0] s;
    logic [N_BITS-1:0] n;
    logic [DBIT-1:0]   b;

    baud_gen #(
        .DVSR      (DVSR),
        .DVSR_BITS (DVSR_BITS)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick)
    );

    // Two-flop synchroniser; reset to the idle level so reset release never
    // looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            wr        <= 1'b0;
            w_data    <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wr        <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                // React to the edge immediately rather than on a tick, so the
                // half-bit count in START is measured from the edge itself.
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                // Eight ticks lands mid start bit; a high line there was a glitch.
                START: begin
                    if (s_tick) begin
                        if (s == S_BITS'(7)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                // Sample once per 16 ticks, mid-bit, shifting in LSB first.
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BITS'(15)) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == N_BITS'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                // Stop bit judged mid-bit; returning to IDLE here leaves half a
                // bit to spare before a back-to-back start edge.
                STOP: begin
                    if (s_tick) begin
                        if (s == S_BITS'(SB_TICK - 1)) begin
                            state <= IDLE;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                wr     <= 1'b1;
                                w_data <= b;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (DVSR=4, 64 clk per bit)
import uart_pkg::*;

module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       fifo_full;
    logic       wr;
    logic [7:0] w_data;
    logic       frame_err;
    logic       overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int cyc = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] wr_data_log [0:63];
    int         wr_time_log [0:63];

    uart_rx #(
        .DBIT      (8),
        .SB_TICK   (16),
        .DVSR      (4),
        .DVSR_BITS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .fifo_full (fifo_full),
        .wr        (wr),
        .w_data    (w_data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count every high cycle of each strobe, so a stretched pulse shows up
    // as an extra event.
    always @(negedge clk) begin
        if (wr) begin
            if (wr_cnt < 64) begin
                wr_data_log[wr_cnt] = w_data;
                wr_time_log[wr_cnt] = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun)   ov_cnt = ov_cnt + 1;
    end

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end else begin
            // Low through the stop sample point, high again before the
            // restart from IDLE reaches its own mid-start-bit check.
            rx = 1'b0;
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic check_one_wr(input string name, input logic [7:0] exp_d, input int w0, input int f0, input int o0);
        total_cnt++;
        if (wr_cnt - w0 !== 1) $display("FAIL %s wr count: got %0d expected 1", name, wr_cnt - w0);
        else pass_cnt++;
        total_cnt++;
        if (w_data !== exp_d) $display("FAIL %s w_data: got %h expected %h", name, w_data, exp_d);
        else pass_cnt++;
        total_cnt++;
        if ((fe_cnt - f0) + (ov_cnt - o0) !== 0)
            $display("FAIL %s errors: got fe=%0d ov=%0d expected 0/0", name, fe_cnt - f0, ov_cnt - o0);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({wr, frame_err, overrun, w_data} !== 11'd0)
            $display("FAIL reset outputs: got wr=%b fe=%b ov=%b d=%h expected all 0", wr, frame_err, overrun, w_data);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== IDLE) $display("FAIL reset state: got %0d expected %0d", dut.state, IDLE);
        else pass_cnt++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic();
        int w0 = wr_cnt, f0 = fe_cnt, o0 = ov_cnt;
        int t0 = cyc;
        int lat;
        send_frame(8'h55, 1);
        repeat (40) @(negedge clk);
        check_one_wr("basic_55", 8'h55, w0, f0, o0);
        // Start edge to wr: (8+128+16) ticks * 4 clk plus sync and phase.
        lat = wr_time_log[w0] - t0;
        total_cnt++;
        if (lat < 600 || lat > 625) $display("FAIL basic latency: got %0d expected 600..625", lat);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int w0 = wr_cnt, f0 = fe_cnt, o0 = ov_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        total_cnt++;
        if ((wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0)
            $display("FAIL glitch outputs: got wr=%0d fe=%0d ov=%0d expected 0", wr_cnt - w0, fe_cnt - f0, ov_cnt - o0);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== IDLE) $display("FAIL glitch state: got %0d expected %0d", dut.state, IDLE);
        else pass_cnt++;
        w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA3, 1);
        repeat (40) @(negedge clk);
        check_one_wr("after_glitch_a3", 8'hA3, w0, f0, o0);
    endtask

    task automatic test_frame_err();
        int w0 = wr_cnt, f0 = fe_cnt, o0 = ov_cnt;
        send_frame(8'hA3, 0);
        repeat (100) @(negedge clk);
        total_cnt++;
        if (fe_cnt - f0 !== 1) $display("FAIL frame_err count: got %0d expected 1", fe_cnt - f0);
        else pass_cnt++;
        total_cnt++;
        if ((wr_cnt - w0) + (ov_cnt - o0) !== 0)
            $display("FAIL frame_err others: got wr=%0d ov=%0d expected 0", wr_cnt - w0, ov_cnt - o0);
        else pass_cnt++;
        total_cnt++;
        if (w_data !== 8'hA3) $display("FAIL frame_err w_data held: got %h expected a3", w_data);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int w0 = wr_cnt, f0 = fe_cnt, o0 = ov_cnt;
        fifo_full = 1'b1;
        send_frame(8'h3C, 1);
        repeat (20) @(negedge clk);
        fifo_full = 1'b0;
        total_cnt++;
        if (ov_cnt - o0 !== 1) $display("FAIL overrun count: got %0d expected 1", ov_cnt - o0);
        else pass_cnt++;
        total_cnt++;
        if ((wr_cnt - w0) + (fe_cnt - f0) !== 0)
            $display("FAIL overrun others: got wr=%0d fe=%0d expected 0", wr_cnt - w0, fe_cnt - f0);
        else pass_cnt++;
        total_cnt++;
        if (w_data !== 8'hA3) $display("FAIL overrun w_data held: got %h expected a3", w_data);
        else pass_cnt++;
        w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h3C, 1);
        repeat (40) @(negedge clk);
        check_one_wr("after_overrun_3c", 8'h3C, w0, f0, o0);
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt, f0 = fe_cnt, o0 = ov_cnt;
        int gap;
        send_frame(8'h00, 1);
        send_frame(8'hFF, 1);
        repeat (40) @(negedge clk);
        total_cnt++;
        if (wr_cnt - w0 !== 2) $display("FAIL b2b wr count: got %0d expected 2", wr_cnt - w0);
        else pass_cnt++;
        total_cnt++;
        if (wr_data_log[w0] !== 8'h00) $display("FAIL b2b first data: got %h expected 00", wr_data_log[w0]);
        else pass_cnt++;
        total_cnt++;
        if (wr_data_log[w0+1] !== 8'hFF) $display("FAIL b2b second data: got %h expected ff", wr_data_log[w0+1]);
        else pass_cnt++;
        gap = wr_time_log[w0+1] - wr_time_log[w0];
        total_cnt++;
        if (gap < 636 || gap > 644) $display("FAIL b2b spacing: got %0d expected 636..644", gap);
        else pass_cnt++;
        total_cnt++;
        if ((fe_cnt - f0) + (ov_cnt - o0) !== 0)
            $display("FAIL b2b errors: got fe=%0d ov=%0d expected 0", fe_cnt - f0, ov_cnt - o0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int w0 = wr_cnt, f0 = fe_cnt, o0 = ov_cnt;
        // Reset lands mid data bit 7 (a 1); the rest of the frame is high,
        // so no false start follows.
        fork
            send_frame(8'h81, 1);
            begin
                repeat (8 * BIT_CLK + 32) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                total_cnt++;
                if ({wr, frame_err, overrun, w_data} !== 11'd0)
                    $display("FAIL midreset outputs: got wr=%b fe=%b ov=%b d=%h expected all 0", wr, frame_err, overrun, w_data);
                else pass_cnt++;
                total_cnt++;
                if (dut.state !== IDLE) $display("FAIL midreset state: got %0d expected %0d", dut.state, IDLE);
                else pass_cnt++;
            end
        join
        repeat (100) @(negedge clk);
        total_cnt++;
        if ((wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0)
            $display("FAIL midreset aborted: got wr=%0d fe=%0d ov=%0d expected 0", wr_cnt - w0, fe_cnt - f0, ov_cnt - o0);
        else pass_cnt++;
        w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h7E, 1);
        repeat (40) @(negedge clk);
        check_one_wr("after_reset_7e", 8'h7E, w0, f0, o0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
